// File: rtl/ddc_pkt_pkg.sv
// Shared constants for the DDC packetizer: header tag, word field positions,
// output FSM encoding and small word-packing helpers.
package ddc_pkt_pkg;

  localparam logic [31:0] MagicDefault = 32'hDDC0_0C7A;

  localparam int unsigned SampleW = 96;
  localparam int unsigned WordW   = 128;

  // Header word layout
  localparam int unsigned HdrMagicLsb = 96;
  localparam int unsigned HdrSeqLsb   = 64;
  localparam int unsigned HdrNchLsb   = 56;
  localparam int unsigned HdrDropLsb  = 0;

  // Data word layout
  localparam int unsigned DataIdxLsb    = 120;
  localparam int unsigned DataSampleLsb = 0;

  // Output FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StHdr  = 2'd1;
  localparam state_t StData = 2'd2;

  function automatic logic [WordW-1:0] pack_header(input logic [31:0] magic,
                                                   input logic [31:0] seq,
                                                   input logic [7:0]  nch,
                                                   input logic [31:0] drops);
    logic [WordW-1:0] w;
    w = '0;
    w[HdrMagicLsb +: 32] = magic;
    w[HdrSeqLsb +: 32]   = seq;
    w[HdrNchLsb +: 8]    = nch;
    w[HdrDropLsb +: 32]  = drops;
    return w;
  endfunction

  function automatic logic [WordW-1:0] pack_data(input logic [7:0]         idx,
                                                 input logic [SampleW-1:0] sample);
    logic [WordW-1:0] w;
    w = '0;
    w[DataIdxLsb +: 8]          = idx;
    w[DataSampleLsb +: SampleW] = sample;
    return w;
  endfunction

endpackage

// File: rtl/ddc_pkt_ram.sv
// Simple dual-port sample store: one write port, one read port with a
// registered output. Contents are not reset.
module ddc_pkt_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 96,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Write port plus registered read (read-before-write on address collision)
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ddc_packetizer.sv
// DDC frame packetizer. Collects N_CH per-channel samples into a FIFO,
// committing a frame only when all beats arrived back-to-back, and emits each
// committed frame as a header word followed by N_CH data words.
module ddc_packetizer
  import ddc_pkt_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter logic [31:0] MAGIC      = MagicDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SampleW-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [WordW-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [31:0]        drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  // One extra pointer bit separates full from empty.
  localparam int unsigned PW = AW + 1;

  localparam logic [7:0]    LastIdx = 8'(N_CH - 1);
  localparam logic [7:0]    NchByte = 8'(N_CH);
  localparam logic [PW-1:0] DepthP  = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] NchP    = PW'(N_CH);

  // Input side state
  logic [7:0]    in_idx_q, in_idx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic          discard_q, discard_d;
  logic [31:0]   drop_count_q, drop_count_d;

  // Shared between both sides
  logic [PW-1:0] frames_ready_q, frames_ready_d;

  // Output side state
  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    k_q, k_d;
  logic [31:0]   frame_seq_q, frame_seq_d;
  logic [31:0]   hdr_drop_q, hdr_drop_d;

  // Per-cycle events
  logic          ram_we;
  logic          commit;
  logic          drop_inc;
  logic          hdr_taken;
  logic          frame_first;
  logic          frame_last;
  logic          frame_fits;
  logic [PW-1:0] fill;
  logic [PW-1:0] free_space;

  logic [SampleW-1:0] ram_rdata;

  // Upstream never honours backpressure; loss is handled by discarding frames.
  assign s_axis_tready = 1'b1;

  ddc_pkt_ram #(
    .Depth(FIFO_DEPTH),
    .Width(SampleW),
    .AddrW(AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i(s_axis_tdata),
    .raddr_i(rd_ptr_d[AW-1:0]),
    .rdata_o(ram_rdata)
  );

  // Input side: speculative write, commit on the last beat, roll back on a gap
  always_comb begin
    in_idx_d    = in_idx_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    discard_d   = discard_q;
    ram_we      = 1'b0;
    commit      = 1'b0;
    drop_inc    = 1'b0;

    // rd_ptr_q still owns the word on the output, so its slot is not free yet.
    fill        = wr_ptr_q - rd_ptr_q;
    free_space  = DepthP - fill;
    frame_first = (in_idx_q == 8'd0);
    frame_last  = (in_idx_q == LastIdx);
    frame_fits  = frame_first ? (free_space >= NchP) : !discard_q;

    if (s_axis_tvalid) begin
      if (frame_first && !frame_fits) begin
        discard_d = 1'b1;
        drop_inc  = 1'b1;
      end
      if (frame_fits) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (frame_last) begin
          wr_commit_d = wr_ptr_q + PW'(1);
          commit      = 1'b1;
        end
      end
      if (frame_last) begin
        in_idx_d  = 8'd0;
        discard_d = 1'b0;
      end else begin
        in_idx_d = in_idx_q + 8'd1;
      end
    end else if (!frame_first) begin
      // Broken frame: forget its words; a frame already being discarded is
      // counted only once.
      wr_ptr_d  = wr_commit_q;
      in_idx_d  = 8'd0;
      drop_inc  = !discard_q;
      discard_d = 1'b0;
    end
  end

  // Saturating count of discarded frames
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_inc && (drop_count_q != 32'hFFFF_FFFF)) begin
      drop_count_d = drop_count_q + 32'd1;
    end
  end

  // Output FSM. rd_ptr_d addresses the word shown next cycle, so the
  // registered RAM read always lines up with the word on the bus.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    k_d         = k_q;
    frame_seq_d = frame_seq_q;
    hdr_drop_d  = hdr_drop_q;
    hdr_taken   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frames_ready_q != '0) begin
          state_d    = StHdr;
          hdr_drop_d = drop_count_q;
        end
      end
      StHdr: begin
        if (m_axis_tready) begin
          state_d     = StData;
          k_d         = 8'd0;
          hdr_taken   = 1'b1;
          frame_seq_d = frame_seq_q + 32'd1;
        end
      end
      StData: begin
        if (m_axis_tready) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (k_q == LastIdx) begin
            // A frame committing this cycle can follow without an idle gap.
            if ((frames_ready_q != '0) || commit) begin
              state_d    = StHdr;
              hdr_drop_d = drop_count_q;
            end else begin
              state_d = StIdle;
            end
          end else begin
            k_d = k_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Committed-frame count nets a simultaneous commit and header handshake
  always_comb begin
    frames_ready_d = frames_ready_q;
    case ({commit, hdr_taken})
      2'b10:   frames_ready_d = frames_ready_q + PW'(1);
      2'b01:   frames_ready_d = frames_ready_q - PW'(1);
      default: frames_ready_d = frames_ready_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx_q       <= '0;
      wr_ptr_q       <= '0;
      wr_commit_q    <= '0;
      discard_q      <= 1'b0;
      drop_count_q   <= '0;
      frames_ready_q <= '0;
      state_q        <= StIdle;
      rd_ptr_q       <= '0;
      k_q            <= '0;
      frame_seq_q    <= '0;
      hdr_drop_q     <= '0;
    end else begin
      in_idx_q       <= in_idx_d;
      wr_ptr_q       <= wr_ptr_d;
      wr_commit_q    <= wr_commit_d;
      discard_q      <= discard_d;
      drop_count_q   <= drop_count_d;
      frames_ready_q <= frames_ready_d;
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      k_q            <= k_d;
      frame_seq_q    <= frame_seq_d;
      hdr_drop_q     <= hdr_drop_d;
    end
  end

  // Output word assembly; every input is a register, so stalls hold the bus
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (state_q)
      StHdr: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = pack_header(MAGIC, frame_seq_q, NchByte, hdr_drop_q);
      end
      StData: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = pack_data(k_q, ram_rdata);
        m_axis_tlast  = (k_q == LastIdx);
      end
      default: begin
        m_axis_tvalid = 1'b0;
      end
    endcase
  end

  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_ddc_packetizer.sv
// Scoreboard bench for ddc_packetizer (N_CH=4, FIFO_DEPTH=16). Stimulus pushes
// expected words; a negedge monitor pops and compares each handshake, checks
// bus stability during stalls and evaluates queued direct checks.
module tb_ddc_packetizer;

  localparam int unsigned NCh   = 4;
  localparam int unsigned Depth = 16;
  localparam logic [31:0] Magic = 32'hDDC0_0C7A;

  localparam logic [7:0] ChkRstValid = 8'd0;
  localparam logic [7:0] ChkRstLast  = 8'd1;
  localparam logic [7:0] ChkRstData  = 8'd2;
  localparam logic [7:0] ChkRstDrops = 8'd3;
  localparam logic [7:0] ChkSReady   = 8'd4;
  localparam logic [7:0] ChkLatency  = 8'd5;
  localparam logic [7:0] ChkDrops    = 8'd6;
  localparam logic [7:0] ChkDrain    = 8'd7;
  localparam logic [7:0] ChkSpace    = 8'd8;
  localparam logic [7:0] ChkWord2    = 8'd9;
  localparam logic [7:0] ChkMidRst   = 8'd10;
  localparam logic [7:0] ChkEndEmpty = 8'd11;

  logic         clk = 1'b0;
  logic         rst;
  logic [95:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic [31:0]  drop_count;

  logic rdy_fixed = 1'b0;
  logic rand_rdy  = 1'b0;
  int   cyc       = 0;
  int   checks    = 0;
  int   failures  = 0;

  typedef struct packed {
    logic [7:0]   id;
    logic [128:0] act;
    logic [128:0] exp;
  } dchk_t;

  logic [128:0] exp_q[$];
  dchk_t        dir_q[$];

  ddc_packetizer #(
    .N_CH      (NCh),
    .FIFO_DEPTH(Depth),
    .MAGIC     (Magic)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: fixed level or 30% random duty
  always @(posedge clk) begin
    #1;
    if (rand_rdy) m_axis_tready = ($urandom_range(0, 99) < 30);
    else m_axis_tready = rdy_fixed;
  end

  function automatic string chk_name(input logic [7:0] id);
    case (id)
      ChkRstValid: return "reset_tvalid";
      ChkRstLast:  return "reset_tlast";
      ChkRstData:  return "reset_tdata";
      ChkRstDrops: return "reset_drop_count";
      ChkSReady:   return "s_tready_const";
      ChkLatency:  return "header_latency";
      ChkDrops:    return "drop_count";
      ChkDrain:    return "drain_timeout";
      ChkSpace:    return "space_wait_timeout";
      ChkWord2:    return "word2_wait_timeout";
      ChkMidRst:   return "tvalid_after_mid_reset";
      ChkEndEmpty: return "scoreboard_empty_at_end";
      default:     return "unknown";
    endcase
  endfunction

  // Sample k of frame f: I = 16f+k+1, Q = -I
  function automatic logic [95:0] smp(input int f, input int k);
    logic signed [47:0] i_v;
    logic signed [47:0] q_v;
    i_v = 48'(f * 16 + k + 1);
    q_v = -i_v;
    return {q_v, i_v};
  endfunction

  function automatic logic [128:0] exp_hdr(input logic [31:0] seq, input logic [31:0] drops);
    return {1'b0, Magic, seq, 8'(NCh), 24'd0, drops};
  endfunction

  function automatic logic [128:0] exp_data(input int k, input logic [95:0] s);
    return {(k == NCh - 1), 8'(k), 24'd0, s};
  endfunction

  task automatic check(input logic [7:0] id, input logic [128:0] act, input logic [128:0] exp);
    dchk_t c;
    c.id  = id;
    c.act = act;
    c.exp = exp;
    dir_q.push_back(c);
  endtask

  task automatic push_packet(input logic [31:0] seq, input logic [31:0] drops, input int f);
    exp_q.push_back(exp_hdr(seq, drops));
    for (int k = 0; k < NCh; k++) exp_q.push_back(exp_data(k, smp(f, k)));
  endtask

  task automatic send_frame(input int f, input int nbeats, output int last_cyc);
    last_cyc = cyc;
    for (int k = 0; k < nbeats; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = smp(f, k);
      last_cyc      = cyc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(ChkDrain, 129'(exp_q.size()), 129'(0));
    idle(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    exp_q.delete();
    rst = 1'b0;
  endtask

  // Monitor: direct checks, stall stability and scoreboard comparison
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data  = '0;
  logic         prev_last  = 1'b0;
  logic [128:0] mon_exp;
  dchk_t        mon_c;

  always @(negedge clk) begin
    while (dir_q.size() != 0) begin
      mon_c = dir_q.pop_front();
      checks++;
      if (mon_c.act !== mon_c.exp) begin
        failures++;
        $display("FAIL %s got %h want %h", chk_name(mon_c.id), mon_c.act, mon_c.exp);
      end
    end
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          failures++;
          $display("FAIL stall_hold got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_word got %h want none", {m_axis_tlast, m_axis_tdata});
        end else begin
          mon_exp = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== mon_exp) begin
            failures++;
            $display("FAIL out_word got %h want %h", {m_axis_tlast, m_axis_tdata}, mon_exp);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  initial begin
    int        t_last;
    int        dummy;
    int        n;
    logic [31:0] seq;

    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check(ChkRstValid, 129'(m_axis_tvalid), 129'(0));
    check(ChkRstLast, 129'(m_axis_tlast), 129'(0));
    check(ChkRstData, 129'(m_axis_tdata), 129'(0));
    check(ChkRstDrops, 129'(drop_count), 129'(0));
    check(ChkSReady, 129'(s_axis_tready), 129'(1));
    rst = 1'b0;
    rdy_fixed = 1'b1;
    idle(3);

    // Single frame; header two cycles after the cycle holding the last beat
    push_packet(32'd0, 32'd0, 0);
    send_frame(0, NCh, t_last);
    s_axis_tvalid = 1'b0;
    n = 0;
    while (!m_axis_tvalid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(ChkLatency, 129'(cyc - t_last), 129'(2));
    drain(200);

    // Two beats, one-cycle gap, then a full frame
    push_packet(32'd1, 32'd1, 2);
    send_frame(1, 2, dummy);
    idle(1);
    send_frame(2, NCh, dummy);
    idle(1);
    drain(200);
    check(ChkDrops, 129'(drop_count), 129'(1));

    // Overflow with downstream stalled: fifth frame dropped
    do_reset();
    rdy_fixed = 1'b0;
    idle(3);
    push_packet(32'd0, 32'd0, 10);
    push_packet(32'd1, 32'd1, 11);
    push_packet(32'd2, 32'd1, 12);
    push_packet(32'd3, 32'd1, 13);
    for (int f = 10; f < 15; f++) send_frame(f, NCh, dummy);
    idle(6);
    check(ChkDrops, 129'(drop_count), 129'(1));
    rdy_fixed = 1'b1;
    drain(300);

    // 1000 frames against random ready
    seq = 32'd4;
    rand_rdy = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      n = 0;
      while (exp_q.size() > 10 && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 2000) begin
        check(ChkSpace, 129'(exp_q.size()), 129'(0));
        break;
      end
      push_packet(seq, 32'd1, 100 + f);
      seq = seq + 32'd1;
      send_frame(100 + f, NCh, dummy);
      s_axis_tvalid = 1'b0;
    end
    drain(2000);
    rand_rdy = 1'b0;
    idle(2);
    check(ChkDrops, 129'(drop_count), 129'(1));

    // Sequence number wrap
    force dut.frame_seq_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.frame_seq_q;
    idle(1);
    push_packet(32'hFFFF_FFFF, 32'd1, 40);
    push_packet(32'h0000_0000, 32'd1, 41);
    send_frame(40, NCh, dummy);
    send_frame(41, NCh, dummy);
    idle(1);
    drain(200);

    // Reset while data word 2 is on the bus
    push_packet(32'd1, 32'd1, 50);
    send_frame(50, NCh, dummy);
    s_axis_tvalid = 1'b0;
    n = 0;
    while (!(m_axis_tvalid && m_axis_tdata[127:120] == 8'd2) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(ChkWord2, 129'(n >= 50), 129'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check(ChkMidRst, 129'(m_axis_tvalid), 129'(0));
    check(ChkRstDrops, 129'(drop_count), 129'(0));
    exp_q.delete();
    rst = 1'b0;
    idle(2);
    push_packet(32'd0, 32'd0, 60);
    send_frame(60, NCh, dummy);
    idle(1);
    drain(200);

    check(ChkEndEmpty, 129'(exp_q.size()), 129'(0));
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
